// File: rtl/add_head_tap_pkg.sv
// Shared definitions for the head-tap inserter: state encoding, count width
// and a saturating increment used for the per-frame sample counter.
// No ports; imported by add_head_tap.
package add_head_tap_pkg;

    // Width of the head-tap count (num / num_lat / cnt).
    localparam int NUM_W = 10;

    typedef enum logic [1:0] {
        FILL   = 2'd0,  // emitting FILL_VAL while the delay line primes
        STREAM = 2'd1,  // emitting samples delayed by num_lat valids
        DRAIN  = 2'd2   // flushing buffered samples after ilast
    } state_t;

    // Increment that sticks at lim; the frame counter must never wrap.
    function automatic logic [NUM_W-1:0] sat_inc(input logic [NUM_W-1:0] c,
                                                 input logic [NUM_W-1:0] lim);
        return (c >= lim) ? lim : c + NUM_W'(1);
    endfunction

endpackage

// File: rtl/add_head_tap_dpram.sv
// Delay-line storage: simple dual-port RAM, one write port, one registered read port.
// Latency: rdata valid 1 cycle after re; reads of the address being written return the old word.
// Backpressure: none; contents are never reset.
// Ports: clk; we/waddr/wdata write side; re/raddr/rdata read side.
module head_tap_dpram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/add_head_tap.sv
// Prepends num_lat FILL_VAL samples to every frame by delaying the stream num_lat valids.
// Latency: ovld/odata/olast 1 cycle after the qualifying ivld; drained samples follow back-to-back.
// Backpressure: none; an ivld arriving while draining is dropped and flagged on err_ovf.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   cfg_rst           one-cycle pulse: re-arm to FILL and latch the synchronised num
//   num               head-tap count, quasi-static, may be driven from another clock domain
//   ivld/idata/ilast  input sample stream
//   ovld/odata/olast  output sample stream
//   err_ovf           one-cycle pulse when an ivld was dropped during DRAIN
//
// Build option: define ADD_HEAD_TAP_DRAIN_EN to flush the buffered tail of each frame after
// ilast (DRAIN state). Without it, olast rides on the ilast sample's own output, the buffered
// tail is discarded and err_ovf is tied low.
//
// DEPTH_LOG2 must be at least NUM_W so that every num_lat fits inside the delay line.
module add_head_tap
    import add_head_tap_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] FILL_VAL   = '0,
    parameter int                DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_rst,
    input  logic [NUM_W-1:0]  num,
    input  logic              ivld,
    input  logic [DATA_W-1:0] idata,
    input  logic              ilast,
    output logic              ovld,
    output logic [DATA_W-1:0] odata,
    output logic              olast,
    output logic              err_ovf
);

    state_t                state, state_nx;
    logic [DEPTH_LOG2-1:0] wp, wp_nx;
    logic [NUM_W-1:0]      cnt, cnt_nx, cnt_inc;
    logic [NUM_W-1:0]      num_d1, num_d2, num_lat;

    logic                  ovld_nx, olast_nx;
    logic [DATA_W-1:0]     odata_r, odata_nx;
    // When set, the current output word comes straight from the RAM read register.
    logic                  src_ram, src_ram_nx;

    logic                  ram_we, ram_re;
    logic [DEPTH_LOG2-1:0] ram_raddr;
    logic [DATA_W-1:0]     ram_rdata;

`ifdef ADD_HEAD_TAP_DRAIN_EN
    logic [NUM_W-1:0]      drn, drn_nx;   // samples still to flush
    logic                  err_r, err_nx;
`endif

    head_tap_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_dpram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wp),
        .wdata (idata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // The RAM read register already sits on the output timing boundary, so
    // odata only selects between two registered sources.
    assign odata = src_ram ? ram_rdata : odata_r;

    assign cnt_inc = sat_inc(cnt, num_lat);

    always_comb begin
        state_nx   = state;
        wp_nx      = wp;
        cnt_nx     = cnt;
        ovld_nx    = 1'b0;
        olast_nx   = 1'b0;
        src_ram_nx = 1'b0;
        odata_nx   = odata_r;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_raddr  = wp - DEPTH_LOG2'(num_lat);
`ifdef ADD_HEAD_TAP_DRAIN_EN
        drn_nx     = drn;
        err_nx     = 1'b0;
`endif

        // Keep the last RAM-sourced word visible once the RAM stops being selected.
        if (src_ram) begin
            odata_nx = ram_rdata;
        end

        if (cfg_rst) begin
            state_nx = FILL;
            wp_nx    = '0;
            cnt_nx   = '0;
`ifdef ADD_HEAD_TAP_DRAIN_EN
            drn_nx   = '0;
`endif
        end else begin
            case (state)
                FILL, STREAM: begin
                    if (ivld) begin
                        ram_we  = 1'b1;
                        wp_nx   = wp + DEPTH_LOG2'(1);
                        cnt_nx  = cnt_inc;
                        ovld_nx = 1'b1;
                        if (num_lat == '0) begin
                            // Zero delay: the word being written is the one to emit,
                            // so bypass the RAM rather than read a stale location.
                            odata_nx = idata;
                        end else if (state == FILL) begin
                            odata_nx = FILL_VAL;
                        end else begin
                            ram_re     = 1'b1;
                            src_ram_nx = 1'b1;
                        end

                        if (ilast) begin
`ifdef ADD_HEAD_TAP_DRAIN_EN
                            if (num_lat != '0) begin
                                // cnt_inc already counts this sample and is capped at
                                // num_lat, so it equals min(samples, num_lat).
                                state_nx = DRAIN;
                                drn_nx   = cnt_inc;
                            end else begin
                                olast_nx = 1'b1;
                                state_nx = FILL;
                                wp_nx    = '0;
                                cnt_nx   = '0;
                            end
`else
                            olast_nx = 1'b1;
                            state_nx = FILL;
                            wp_nx    = '0;
                            cnt_nx   = '0;
`endif
                        end else if (state == FILL && num_lat != '0 && cnt_inc == num_lat) begin
                            state_nx = STREAM;
                        end
                    end
                end

`ifdef ADD_HEAD_TAP_DRAIN_EN
                DRAIN: begin
                    // wp points just past the ilast sample; flush wp-drn upward.
                    ram_re     = 1'b1;
                    ram_raddr  = wp - DEPTH_LOG2'(drn);
                    ovld_nx    = 1'b1;
                    src_ram_nx = 1'b1;
                    drn_nx     = drn - NUM_W'(1);
                    err_nx     = ivld;
                    if (drn == NUM_W'(1)) begin
                        olast_nx = 1'b1;
                        state_nx = FILL;
                        wp_nx    = '0;
                        cnt_nx   = '0;
                    end
                end
`endif

                default: begin
                    state_nx = FILL;
                    wp_nx    = '0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            wp      <= '0;
            cnt     <= '0;
            num_d1  <= '0;
            num_d2  <= '0;
            num_lat <= '0;
            ovld    <= 1'b0;
            olast   <= 1'b0;
            odata_r <= '0;
            src_ram <= 1'b0;
        end else begin
            // num may come from another clock domain and is only sampled on cfg_rst.
            num_d1  <= num;
            num_d2  <= num_d1;
            if (cfg_rst) begin
                num_lat <= num_d2;
            end
            state   <= state_nx;
            wp      <= wp_nx;
            cnt     <= cnt_nx;
            ovld    <= ovld_nx;
            olast   <= olast_nx;
            odata_r <= odata_nx;
            src_ram <= src_ram_nx;
        end
    end

`ifdef ADD_HEAD_TAP_DRAIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drn   <= '0;
            err_r <= 1'b0;
        end else begin
            drn   <= drn_nx;
            err_r <= err_nx;
        end
    end

    assign err_ovf = err_r;
`else
    assign err_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_add_head_tap.sv
// Self-checking bench for add_head_tap: reset values, a fixed vector table, directed
// multi-cycle sequences (long frame, short frame drain, cfg abort, overflow) and random
// traffic, all compared cycle by cycle against a queue-based frame model.
module tb_add_head_tap;

`ifdef ADD_HEAD_TAP_DRAIN_EN
    localparam bit DRAIN_ON = 1'b1;
`else
    localparam bit DRAIN_ON = 1'b0;
`endif
    localparam logic [15:0] FILL_V = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_rst = 1'b0;
    logic [9:0]  num = '0;
    logic        ivld = 1'b0;
    logic [15:0] idata = '0;
    logic        ilast = 1'b0;
    logic        ovld, olast, err_ovf;
    logic [15:0] odata;

    int errs = 0;
    int checks = 0;
    int nout = 0;

    add_head_tap #(
        .DATA_W     (16),
        .FILL_VAL   (16'h0000),
        .DEPTH_LOG2 (10)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_rst (cfg_rst),
        .num     (num),
        .ivld    (ivld),
        .idata   (idata),
        .ilast   (ilast),
        .ovld    (ovld),
        .odata   (odata),
        .olast   (olast),
        .err_ovf (err_ovf)
    );

    always #5 clk = ~clk;

    // Frame model: samples of the current frame, pending drain words, latched delay.
    logic [15:0] fr[$];
    logic [15:0] dq[$];
    int          lat = 0;

    typedef struct {
        logic [9:0]  num;
        logic        cfg;
        logic        v;
        logic        l;
        logic [15:0] d;
        logic        ev;
        logic        el;
        logic [15:0] ed;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic [9:0] n, input logic c, input logic v,
                                input logic l, input logic [15:0] d, input logic ev,
                                input logic el, input logic [15:0] ed);
        vec_t r;
        r.num = n; r.cfg = c; r.v = v; r.l = l; r.d = d;
        r.ev = ev; r.el = el; r.ed = ed;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, predict this cycle's outputs from the frame model,
    // take the edge and compare 1 time unit later.
    task automatic tick(input logic v, input logic [15:0] d, input logic l, input logic c);
        logic        ev, el, ee;
        logic [15:0] ed;
        int          i, k;
        ivld = v; idata = d; ilast = l; cfg_rst = c;
        ev = 1'b0; el = 1'b0; ee = 1'b0; ed = '0;
        if (c) begin
            fr.delete();
            dq.delete();
            lat = int'(num);
        end else if (dq.size() > 0) begin
            ev = 1'b1;
            ed = dq.pop_front();
            el = (dq.size() == 0);
            ee = v;
        end else if (v) begin
            i = fr.size();
            fr.push_back(d);
            ev = 1'b1;
            ed = (i < lat) ? FILL_V : fr[i - lat];
            if (l) begin
                k = (fr.size() < lat) ? fr.size() : lat;
                if (DRAIN_ON) begin
                    for (int j = fr.size() - k; j < fr.size(); j++) dq.push_back(fr[j]);
                end
                el = (dq.size() == 0);
                fr.delete();
            end
        end
        @(posedge clk);
        #1;
        if (ovld === 1'b1) nout++;
        chk("ovld", ovld, ev);
        chk("err_ovf", err_ovf, ee);
        if (ev) begin
            chk("odata", odata, ed);
            chk("olast", olast, el);
        end else begin
            chk("olast_idle", olast, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic configure(input logic [9:0] n);
        num = n;
        idle(3);
        tick(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    initial begin
        int n0;
        logic v, l;

        // Reset values
        #12;
        chk("rst_ovld", ovld, 1'b0);
        chk("rst_olast", olast, 1'b0);
        chk("rst_err", err_ovf, 1'b0);
        chk("rst_odata", odata, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fixed vectors: num=0 pass-through, then num=3 frame A1..A6
        for (int j = 0; j < 3; j++) add(10'd0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
        add(10'd0, 1, 0, 0, 16'h0, 0, 0, 16'h0);
        add(10'd0, 0, 1, 0, 16'h0011, 1, 0, 16'h0011);
        add(10'd0, 0, 1, 0, 16'h0022, 1, 0, 16'h0022);
        add(10'd0, 0, 1, 0, 16'h0033, 1, 0, 16'h0033);
        add(10'd0, 0, 1, 1, 16'h0044, 1, 1, 16'h0044);
        add(10'd0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
        for (int j = 0; j < 3; j++) add(10'd3, 0, 0, 0, 16'h0, 0, 0, 16'h0);
        add(10'd3, 1, 0, 0, 16'h0, 0, 0, 16'h0);
        add(10'd3, 0, 1, 0, 16'h00A1, 1, 0, 16'h0000);
        add(10'd3, 0, 1, 0, 16'h00A2, 1, 0, 16'h0000);
        add(10'd3, 0, 1, 0, 16'h00A3, 1, 0, 16'h0000);
        add(10'd3, 0, 1, 0, 16'h00A4, 1, 0, 16'h00A1);
        add(10'd3, 0, 1, 0, 16'h00A5, 1, 0, 16'h00A2);
        add(10'd3, 0, 1, 1, 16'h00A6, 1, !DRAIN_ON, 16'h00A3);
        add(10'd3, 0, 0, 0, 16'h0, DRAIN_ON, 0, 16'h00A4);
        add(10'd3, 0, 0, 0, 16'h0, DRAIN_ON, 0, 16'h00A5);
        add(10'd3, 0, 0, 0, 16'h0, DRAIN_ON, DRAIN_ON, 16'h00A6);
        add(10'd3, 0, 0, 0, 16'h0, 0, 0, 16'h0);

        for (int r = 0; r < tbl.size(); r++) begin
            num = tbl[r].num;
            tick(tbl[r].v, tbl[r].d, tbl[r].l, tbl[r].cfg);
            chk("tbl_ovld", ovld, tbl[r].ev);
            if (tbl[r].ev) begin
                chk("tbl_odata", odata, tbl[r].ed);
                chk("tbl_olast", olast, tbl[r].el);
            end
        end

        // Maximum delay with a long frame
        configure(10'd1023);
        n0 = nout;
        for (int j = 0; j < 2000; j++) tick(1'b1, 16'(j), (j == 1999), 1'b0);
        idle(1030);
        chk("long_total", nout - n0, DRAIN_ON ? 3023 : 2000);

        // Frame shorter than the delay
        configure(10'd4);
        n0 = nout;
        tick(1'b1, 16'h1234, 1'b0, 1'b0);
        tick(1'b1, 16'h5678, 1'b1, 1'b0);
        idle(4);
        chk("short_total", nout - n0, DRAIN_ON ? 4 : 2);

        // cfg_rst two cycles into a drain, then a fresh frame
        configure(10'd5);
        for (int j = 0; j < 7; j++) tick(1'b1, 16'h0100 + 16'(j), (j == 6), 1'b0);
        idle(2);
        tick(1'b0, 16'h0, 1'b0, 1'b1);
        chk("abort_ovld", ovld, 1'b0);
        chk("abort_olast", olast, 1'b0);
        for (int j = 0; j < 3; j++) tick(1'b1, 16'h0200 + 16'(j), (j == 2), 1'b0);
        idle(6);

        // ivld arriving while draining
        configure(10'd3);
        for (int j = 0; j < 5; j++) tick(1'b1, 16'h0300 + 16'(j), (j == 4), 1'b0);
        idle(1);
        tick(1'b1, 16'hBEEF, 1'b0, 1'b0);
        chk("ovf_pulse", err_ovf, DRAIN_ON);
        idle(1);
        chk("ovf_clear", err_ovf, 1'b0);
        idle(3);

        // Random traffic over random delays
        for (int r = 0; r < 20; r++) begin
            case ($urandom_range(0, 5))
                0:       configure(10'd0);
                1:       configure(10'd1);
                2:       configure(10'd1023);
                default: configure(10'($urandom_range(2, 40)));
            endcase
            for (int j = 0; j < 150; j++) begin
                v = ($urandom_range(0, 9) < 7);
                l = v && ($urandom_range(0, 19) == 0);
                tick(v, 16'($urandom), l, 1'b0);
            end
        end
        idle(1100);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
